// File: rtl/fifo_arbiter_ctrl.sv
// Four-into-one FIFO drain controller: threshold configuration, state sequencing
// and a round-robin arbiter with back-pressure on the sink's almost_full.
module fifo_arbiter_ctrl #(
  parameter int DATA_WIDTH   = 10,
  parameter int UMBRAL_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRAL_WIDTH-1:0] umbral_bajo_in,
  input  logic [UMBRAL_WIDTH-1:0] umbral_alto_in,
  output logic [UMBRAL_WIDTH-1:0] umbral_bajo,
  output logic [UMBRAL_WIDTH-1:0] umbral_alto,
  input  logic [3:0]              empty_in,
  input  logic [4:0]              error_in,
  input  logic [4*DATA_WIDTH-1:0] data_in,
  output logic [3:0]              pop,
  input  logic                    almost_full_out,
  output logic                    push_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [2:0]              state,
  output logic                    idle,
  output logic                    error_out
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [1:0]              gnt_q, gnt_d;
  logic                    push_q, push_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [UMBRAL_WIDTH-1:0] bajo_q, bajo_d;
  logic [UMBRAL_WIDTH-1:0] alto_q, alto_d;

  logic [DATA_WIDTH-1:0]   src_data [4];
  logic [1:0]              gnt_idx;
  logic                    gnt_found;
  logic                    grant_valid;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_src
      assign src_data[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // First non-empty source at or after the pointer, scanning modulo 4.
  always_comb begin
    logic [1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!gnt_found && !empty_in[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant_valid = (state_q == ST_ACTIVE) && !almost_full_out && gnt_found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  if (init) state_d = ST_INIT;
      ST_INIT: begin
        if (!init) begin
          state_d = (umbral_bajo_in < umbral_alto_in) ? ST_IDLE : ST_ERROR;
        end
      end
      ST_IDLE: begin
        if (|error_in)       state_d = ST_ERROR;
        else if (init)       state_d = ST_INIT;
        else if (~&empty_in) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (|error_in)                 state_d = ST_ERROR;
        else if (&empty_in && !push_q) state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
  end

  always_comb begin
    pop       = grant_valid ? (4'b0001 << gnt_idx) : 4'b0000;
    idle      = (state_q == ST_IDLE);
    error_out = (state_q == ST_ERROR);
    state     = state_q;
  end

  // Pops issued before an error still complete, so push_d ignores the state change.
  always_comb begin
    push_d = grant_valid;
    gnt_d  = grant_valid ? gnt_idx : gnt_q;
    ptr_d  = grant_valid ? gnt_idx + 2'd1 : ptr_q;
    hold_d = push_q ? src_data[gnt_q] : hold_q;
    bajo_d = (state_q == ST_INIT) ? umbral_bajo_in : bajo_q;
    alto_d = (state_q == ST_INIT) ? umbral_alto_in : alto_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= 2'd0;
      gnt_q  <= 2'd0;
      push_q <= 1'b0;
      hold_q <= '0;
      bajo_q <= '0;
      alto_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      push_q <= push_d;
      hold_q <= hold_d;
      bajo_q <= bajo_d;
      alto_q <= alto_d;
    end
  end

  // Source read data arrives the cycle after the pop, so it is forwarded
  // during the push cycle and held in hold_q afterwards.
  assign push_out    = push_q;
  assign data_out    = push_q ? src_data[gnt_q] : hold_q;
  assign umbral_bajo = bajo_q;
  assign umbral_alto = alto_q;

endmodule
